jogador_automatico: RTL and testbench

- Synthesizable automatic player for the jogo_playseq memory game.
- Watches the game's `leds` while the sequence is shown and records each displayed step into an internal 16-entry buffer.
- Once display ends, replays the recorded steps on `botoes` with fixed press/release timing.
- Sits beside jogo_playseq on the FPGA top. Used for self-play demos and hardware regression in place of a human player.

---
 rtl/jogador_automatico_pkg.sv | 17 +
 rtl/jogador_automatico_if.sv | 23 ++
 rtl/jogador_automatico_temporizador.sv | 21 ++
 rtl/jogador_automatico.sv | 128 ++++++++++++
 tb/tb_jogador_automatico.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/jogador_automatico_pkg.sv
// jogo_pkg: shared types and helpers for the automatic memory-game player.
// Contents: estado_jogador_t (fixed debug codes), SEQ_W (LED/button width), eh_onehot().
package jogo_pkg;
    localparam int SEQ_W = 4;
    typedef enum logic [3:0] {
        INICIAL      = 4'd0,
        ESPERA_EXIBE = 4'd1,
        CAPTURA      = 4'd2,
        ESPERA_RESP  = 4'd3,
        PRESSIONA    = 4'd4,
        SOLTA        = 4'd5,
        FIM          = 4'd6
    } estado_jogador_t;
    function automatic logic eh_onehot(input logic [SEQ_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction
endpackage

// File: rtl/jogador_automatico_if.sv
// jogador_automatico_if: game-side signal bundle between jogo_playseq and the automatic player.
// master (game side): drives habilita, exibindo, leds, erra; reads botoes, ocupado, n_jogadas, erro_captura, db_estado.
// slave (player side): the opposite directions.
interface jogador_automatico_if;
    import jogo_pkg::*;
    logic habilita;
    logic exibindo;
    logic erra;
    logic [SEQ_W-1:0] leds;
    logic [SEQ_W-1:0] botoes;
    logic ocupado;
    logic erro_captura;
    logic [4:0] n_jogadas;
    logic [3:0] db_estado;
    modport master (
        output habilita, exibindo, leds, erra,
        input  botoes, ocupado, n_jogadas, erro_captura, db_estado
    );
    modport slave (
        input  habilita, exibindo, leds, erra,
        output botoes, ocupado, n_jogadas, erro_captura, db_estado
    );
endinterface

// File: rtl/jogador_automatico_temporizador.sv
// temporizador_jogador: loadable down-counter that stops at zero.
// Ports: clock, reset_n (async, active-low), carga/valor_carga (load), valor (count), zero (count==0).
module temporizador_jogador #(
    parameter int W = 9
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         carga,
    input  logic [W-1:0] valor_carga,
    output logic [W-1:0] valor,
    output logic         zero
);
    assign zero = valor == '0;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)
            valor <= '0;
        else if (carga)
            valor <= valor_carga;
        else if (!zero)
            valor <= valor - 1'b1;
endmodule

// File: rtl/jogador_automatico.sv
// jogador_automatico: records the sequence shown on leds and replays it on botoes.
// Ports: clock, reset_n (async, active-low), jog (jogador_automatico_if.slave: habilita, exibindo,
// leds, erra in; botoes, ocupado, n_jogadas, erro_captura, db_estado out).
// Optional macro JOGADOR_ERRO_EN: when defined, erra=1 at the end of capture rotates the last replayed step.
module jogador_automatico
    import jogo_pkg::*;
#(
    parameter int MAX_SEQ      = 16,
    parameter int RESP_CYCLES  = 500,
    parameter int PRESS_CYCLES = 500,
    parameter int GAP_CYCLES   = 500
) (
    input logic                 clock,
    input logic                 reset_n,
    jogador_automatico_if.slave jog
);
    localparam int PW   = $clog2(MAX_SEQ);
    localparam int TMAX = RESP_CYCLES > PRESS_CYCLES ?
                          (RESP_CYCLES > GAP_CYCLES ? RESP_CYCLES : GAP_CYCLES) :
                          (PRESS_CYCLES > GAP_CYCLES ? PRESS_CYCLES : GAP_CYCLES);
    localparam int TW   = TMAX > 2 ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] T_RESP  = TW'(RESP_CYCLES - 1);
    localparam logic [TW-1:0] T_PRESS = TW'(PRESS_CYCLES - 1);
    localparam logic [TW-1:0] T_GAP   = TW'(GAP_CYCLES - 1);
`ifdef JOGADOR_ERRO_EN
    localparam bit ERRO_EN = 1'b1;
`else
    localparam bit ERRO_EN = 1'b0;
`endif
    estado_jogador_t  estado;
    logic [SEQ_W-1:0] memoria [MAX_SEQ];
    logic [SEQ_W-1:0] leds_q, botoes_r, passo;
    logic [4:0]       n_r;
    logic [PW-1:0]    rd, idx;
    logic [TW-1:0]    tempo, valor_carga;
    logic             erro_r, erra_q, evento, grava, abortar, ultimo, carga, zero;
    assign evento  = leds_q == '0 && jog.leds != '0;
    assign grava   = jog.habilita && jog.exibindo && estado == CAPTURA && evento &&
                     eh_onehot(jog.leds) && n_r != 5'(MAX_SEQ);
    assign abortar = jog.exibindo && (estado == ESPERA_RESP || estado == PRESSIONA || estado == SOLTA);
    assign ultimo  = 5'(rd) + 5'd1 == n_r;
    // Step about to be driven: entry 0 when leaving ESPERA_RESP, rd+1 when leaving SOLTA.
    assign idx     = estado == SOLTA ? rd + 1'b1 : '0;
    assign passo   = (ERRO_EN && erra_q && 5'(idx) + 5'd1 == n_r) ?
                     {memoria[idx][SEQ_W-2:0], memoria[idx][SEQ_W-1]} : memoria[idx];
    // CAPTURA keeps reloading the response delay; elsewhere a reload on expiry is harmless
    // outside the replay states and picks the next phase length inside them.
    assign carga       = estado == CAPTURA || tempo == '0;
    assign valor_carga = estado == CAPTURA ? T_RESP : estado == PRESSIONA ? T_GAP : T_PRESS;
    temporizador_jogador #(.W(TW)) u_temporizador (
        .clock      (clock),
        .reset_n    (reset_n),
        .carga      (carga),
        .valor_carga(valor_carga),
        .valor      (tempo),
        .zero       (zero)
    );
    always_ff @(posedge clock)
        if (grava)
            memoria[n_r[PW-1:0]] <= jog.leds;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            estado   <= INICIAL;
            botoes_r <= '0;
            n_r      <= '0;
            erro_r   <= 1'b0;
            leds_q   <= '0;
            rd       <= '0;
            erra_q   <= 1'b0;
        end else begin
            leds_q <= jog.leds;
            if (!jog.habilita) begin
                estado   <= INICIAL;
                botoes_r <= '0;
            end else if (abortar) begin
                estado   <= CAPTURA;
                botoes_r <= '0;
                n_r      <= '0;
            end else
                case (estado)
                    INICIAL: begin
                        erro_r <= 1'b0;
                        estado <= ESPERA_EXIBE;
                    end
                    ESPERA_EXIBE:
                        if (jog.exibindo) begin
                            n_r    <= '0;
                            estado <= CAPTURA;
                        end
                    CAPTURA:
                        if (!jog.exibindo) begin
                            erra_q <= jog.erra;
                            estado <= n_r == '0 ? FIM : ESPERA_RESP;
                        end else if (grava)
                            n_r <= n_r + 5'd1;
                        else if (evento)
                            erro_r <= 1'b1;
                    ESPERA_RESP:
                        if (zero) begin
                            rd       <= '0;
                            botoes_r <= passo;
                            estado   <= PRESSIONA;
                        end
                    PRESSIONA:
                        if (zero) begin
                            botoes_r <= '0;
                            estado   <= SOLTA;
                        end
                    SOLTA:
                        if (zero) begin
                            rd       <= ultimo ? rd : rd + 1'b1;
                            botoes_r <= ultimo ? '0 : passo;
                            estado   <= ultimo ? FIM : PRESSIONA;
                        end
                    FIM: begin
                        botoes_r <= '0;
                        estado   <= ESPERA_EXIBE;
                    end
                    default: estado <= INICIAL;
                endcase
        end
    assign jog.botoes       = botoes_r;
    assign jog.n_jogadas    = n_r;
    assign jog.erro_captura = erro_r;
    assign jog.db_estado    = estado;
    assign jog.ocupado      = estado == CAPTURA || estado == ESPERA_RESP ||
                              estado == PRESSIONA || estado == SOLTA;
endmodule

// File: tb/tb_jogador_automatico.sv
// tb_jogador_automatico: random and directed rounds checked against a timeline model of the replay.
module tb_jogador_automatico;
    localparam int RESP  = 500;
    localparam int PRESS = 500;
    localparam int GAP   = 500;
    localparam int MAXS  = 16;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    jogador_automatico_if jog();
    jogador_automatico #(
        .MAX_SEQ(MAXS), .RESP_CYCLES(RESP), .PRESS_CYCLES(PRESS), .GAP_CYCLES(GAP)
    ) dut (
        .clock  (clk),
        .reset_n(reset_n),
        .jog    (jog)
    );
    always #5 clk = ~clk;
    int cyc = 0;
    int e0 = 0;
    int modo = 0;
    int n_cmp = 0;
    int n_err = 0;
    int exp_n = 0;
    bit exp_erro = 1'b0;
    bit exp_er = 1'b0;
    int exp_seq [MAXS];
    int pulsos [$];
    int invalidos [5] = '{3, 6, 5, 15, 12};
    always @(posedge clk) cyc++;
    task automatic chk(input string nome, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nome, got, want, cyc);
        end
    endtask
    // Replay timeline: t counts clock edges since exibindo was sampled low.
    function automatic int modelo_botoes(input int t);
        int u, s, v;
        if (t < RESP) return 0;
        u = t - RESP;
        s = u / (PRESS + GAP);
        if (s >= exp_n || u % (PRESS + GAP) >= PRESS) return 0;
        v = exp_seq[s];
`ifdef JOGADOR_ERRO_EN
        if (exp_er && s == exp_n - 1) v = v == 8 ? 1 : v * 2;
`endif
        return v;
    endfunction
    always @(negedge clk) begin
        int t;
        if (modo == 1) begin
            chk("captura_botoes", jog.botoes, 0);
            chk("captura_ocupado", jog.ocupado, 1);
        end else if (modo == 2) begin
            t = cyc - e0;
            chk("replay_botoes", jog.botoes, modelo_botoes(t));
            chk("replay_ocupado", jog.ocupado, int'(t < RESP + exp_n * (PRESS + GAP)));
            chk("replay_n_jogadas", jog.n_jogadas, exp_n);
            chk("replay_erro", jog.erro_captura, exp_erro);
        end
    end
    task automatic espera(input int t);
        while (cyc - e0 < t) @(negedge clk);
    endtask
    task automatic captura(input bit ja_captura, input bit er, input int larg, input int gap);
        int cnt;
        bit ruim;
        cnt = 0;
        ruim = 1'b0;
        if (!ja_captura) begin
            jog.exibindo = 1'b1;
            @(negedge clk);
        end
        modo = 1;
        foreach (pulsos[i]) begin
            if ($countones(pulsos[i]) == 1 && cnt < MAXS) begin
                exp_seq[cnt] = pulsos[i];
                cnt++;
            end else
                ruim = 1'b1;
            jog.leds = 4'(pulsos[i]);
            repeat (larg > 0 ? larg : int'($urandom_range(1, 6))) @(negedge clk);
            jog.leds = 4'd0;
            repeat (gap > 0 ? gap : int'($urandom_range(1, 6))) @(negedge clk);
        end
        jog.erra = er;
        jog.exibindo = 1'b0;
        e0 = cyc + 1;
        exp_n = cnt;
        exp_erro = exp_erro | ruim;
        exp_er = er;
        modo = 2;
    endtask
    task automatic fim_rodada();
        espera(RESP + exp_n * (PRESS + GAP));
        modo = 0;
        chk("estado_fim", jog.db_estado, 6);
        @(negedge clk);
        chk("estado_espera_exibe", jog.db_estado, 1);
        chk("ocupado_apos_fim", jog.ocupado, 0);
    endtask
    initial begin
        jog.habilita = 1'b0;
        jog.exibindo = 1'b0;
        jog.leds = 4'd0;
        jog.erra = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_botoes", jog.botoes, 0);
        chk("reset_ocupado", jog.ocupado, 0);
        chk("reset_n_jogadas", jog.n_jogadas, 0);
        chk("reset_erro", jog.erro_captura, 0);
        chk("reset_estado", jog.db_estado, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("inicial_sem_habilita", jog.db_estado, 0);
        jog.habilita = 1'b1;
        @(negedge clk);
        chk("espera_exibe", jog.db_estado, 1);
        pulsos = '{1, 2, 8};
        captura(1'b0, 1'b0, 500, 500);
        chk("nominal_n", jog.n_jogadas, 3);
        chk("nominal_erro", jog.erro_captura, 0);
        espera(RESP - 1);
        chk("nominal_antes_1a", jog.botoes, 0);
        espera(RESP);
        chk("nominal_1a", jog.botoes, 1);
        espera(RESP + PRESS + GAP);
        chk("nominal_2a", jog.botoes, 2);
        espera(RESP + 2 * (PRESS + GAP) + PRESS);
        chk("nominal_gap_final", jog.botoes, 0);
        fim_rodada();
        pulsos = '{4, 2, 1};
        captura(1'b0, 1'b0, 2, 2);
        espera(RESP + 100);
        modo = 0;
        #3 reset_n = 1'b0;
        #1;
        chk("reset_async_botoes", jog.botoes, 0);
        chk("reset_async_ocupado", jog.ocupado, 0);
        chk("reset_async_n", jog.n_jogadas, 0);
        chk("reset_async_estado", jog.db_estado, 0);
        exp_erro = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("pos_reset_espera", jog.db_estado, 1);
        pulsos = '{1, 6, 4, 2};
        captura(1'b0, 1'b0, 3, 3);
        chk("invalido_n", jog.n_jogadas, 3);
        chk("invalido_erro", jog.erro_captura, 1);
        fim_rodada();
        pulsos.delete();
        for (int i = 0; i < 17; i++) pulsos.push_back(1 << $urandom_range(0, 3));
        captura(1'b0, 1'b0, 2, 2);
        chk("overflow_n", jog.n_jogadas, 16);
        chk("overflow_erro", jog.erro_captura, 1);
        fim_rodada();
        pulsos = '{1, 8, 2};
        captura(1'b0, 1'b0, 4, 4);
        espera(RESP + PRESS + GAP + 200);
        chk("antes_abort", jog.botoes, 8);
        modo = 0;
        jog.exibindo = 1'b1;
        @(negedge clk);
        chk("abort_botoes", jog.botoes, 0);
        chk("abort_estado", jog.db_estado, 2);
        chk("abort_n", jog.n_jogadas, 0);
        pulsos = '{4, 1};
        captura(1'b1, 1'b0, 4, 4);
        fim_rodada();
`ifdef JOGADOR_ERRO_EN
        pulsos = '{4, 8};
        captura(1'b0, 1'b1, 3, 3);
        espera(RESP);
        chk("erra_1a", jog.botoes, 4);
        espera(RESP + PRESS + GAP);
        chk("erra_rotacionado", jog.botoes, 1);
        fim_rodada();
`endif
        repeat (3) begin
            pulsos.delete();
            pulsos.push_back(1 << $urandom_range(0, 3));
            repeat ($urandom_range(0, 7))
                pulsos.push_back($urandom_range(0, 5) == 0 ? invalidos[$urandom_range(0, 4)]
                                                          : 1 << $urandom_range(0, 3));
            captura(1'b0, 1'($urandom_range(0, 1)), 0, 0);
            fim_rodada();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
